// File: rtl/attex_bus_ctrl.sv
// SCC68070 bus cycle sequencer for the CD-i MONO1 board: address decode, one-hot
// chip selects, per-target ready (fixed wait or handshake), registered read data and ack/err pulses.
module attex_bus_ctrl #(
  parameter int CDIC_WAIT  = 2,
  parameter int NVRAM_WAIT = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [22:0] addr,
  input  logic [15:0] mcd212_din,
  input  logic        mcd212_ack,
  input  logic [15:0] cdic_din,
  input  logic [15:0] slave_din,
  input  logic        slave_ack,
  input  logic [15:0] nvram_din,
  output logic        cs_mcd212,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_nvram,
  output logic [15:0] data_out,
  output logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;
  typedef enum logic [2:0] {T_NONE, T_ERR, T_MCD, T_CDIC, T_SLAVE, T_NVRAM} tgt_t;

  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_d, tgt_dec;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [23:0] byte_addr;
  logic        ready;
  logic [15:0] rd_mux;
  logic        unused_write;

  // Direction does not change sequencing: writes capture din as well and the CPU ignores it.
  assign unused_write = write_strobe;
  assign byte_addr    = {addr, 1'b0};

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    tgt_dec = T_NONE;
    if ((byte_addr >= 24'h600000 && byte_addr < 24'hD00000) || byte_addr >= 24'hF00000)
      tgt_dec = T_ERR;
    else if (byte_addr[23:16] == 8'h30)
      tgt_dec = T_CDIC;
    else if (byte_addr[23:16] == 8'h31)
      tgt_dec = T_SLAVE;
    else if (byte_addr[23:16] == 8'h32)
      tgt_dec = T_NVRAM;
    else if (byte_addr <= 24'h27FFFF || (byte_addr >= 24'h400000 && byte_addr <= 24'h5FFFFF))
      tgt_dec = T_MCD;
  end

  always_comb begin
    ready  = 1'b0;
    rd_mux = 16'h0000;
    case (tgt_q)
      T_MCD:   begin ready = mcd212_ack;                rd_mux = mcd212_din; end
      T_SLAVE: begin ready = slave_ack;                 rd_mux = slave_din;  end
      T_CDIC:  begin ready = (cnt_q == 8'(CDIC_WAIT));  rd_mux = cdic_din;   end
      T_NVRAM: begin ready = (cnt_q == 8'(NVRAM_WAIT)); rd_mux = nvram_din;  end
      default: begin ready = 1'b0;                      rd_mux = 16'h0000;   end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= T_NONE;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (as && (uds || lds)) begin
          tgt_d = tgt_dec;
          if (tgt_dec == T_ERR) begin
            err_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = 8'd1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Abort beats ready; ready beats timeout.
        if (!as) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (ready) begin
          data_d  = rd_mux;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!as) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_mcd212 = (state_q == ACCESS) && (tgt_q == T_MCD);
    cs_cdic   = (state_q == ACCESS) && (tgt_q == T_CDIC);
    cs_slave  = (state_q == ACCESS) && (tgt_q == T_SLAVE);
    cs_nvram  = (state_q == ACCESS) && (tgt_q == T_NVRAM);
    bus_ack   = (state_q == DONE) && !err_q;
    bus_err   = (state_q == DONE) && err_q;
    data_out  = data_q;
  end

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// Directed bench for attex_bus_ctrl: stimulus pushes expected ack/err and data into a queue,
// a negedge monitor pops and compares on every bus_ack/bus_err pulse.
module tb_attex_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset, as, uds, lds, write_strobe;
  logic [22:0] addr;
  logic [15:0] mcd212_din, cdic_din, slave_din, nvram_din;
  logic        mcd212_ack, slave_ack;
  logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram;
  logic [15:0] data_out;
  logic        bus_ack, bus_err;

  typedef struct {
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  attex_bus_ctrl #(.CDIC_WAIT(2), .NVRAM_WAIT(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .as(as), .uds(uds), .lds(lds), .write_strobe(write_strobe),
    .addr(addr), .mcd212_din(mcd212_din), .mcd212_ack(mcd212_ack), .cdic_din(cdic_din),
    .slave_din(slave_din), .slave_ack(slave_ack), .nvram_din(nvram_din),
    .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
    .data_out(data_out), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_ack || bus_err) begin
      check("ack_err_exclusive", 32'(bus_ack & bus_err), 32'd0);
      if (q.size() == 0) begin
        check("pulse_with_empty_queue", 32'({bus_ack, bus_err}), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bus_err", 32'(bus_err), 32'(e.err));
        if (!e.err) check("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  // Cycle c=0 is the IDLE cycle where the strobe is first presented; ACCESS begins at c=1.
  task automatic do_cycle(input logic [23:0] a, input logic wr, input logic u, input logic l,
                          input int ack_at, input int n_cycles,
                          output int n_mcd, output int n_cdic, output int n_slave,
                          output int n_nvram, output int pulse_at, output int pulses);
    n_mcd = 0; n_cdic = 0; n_slave = 0; n_nvram = 0; pulse_at = -1; pulses = 0;
    addr = a[23:1]; write_strobe = wr; uds = u; lds = l; as = 1'b1;
    for (int c = 0; c < n_cycles; c++) begin
      mcd212_ack = (c == ack_at);
      slave_ack  = (c == ack_at);
      @(negedge clk);
      n_mcd   += int'(cs_mcd212);
      n_cdic  += int'(cs_cdic);
      n_slave += int'(cs_slave);
      n_nvram += int'(cs_nvram);
      if (bus_ack || bus_err) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
      @(posedge clk); #1;
    end
    as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    mcd212_ack = 1'b0; slave_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nm, nc, ns, nn, pa, np;
    reset = 1'b0; as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; addr = '0;
    mcd212_din = 16'h0; cdic_din = 16'h0; slave_din = 16'h0; nvram_din = 16'h0;
    mcd212_ack = 1'b0; slave_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err}), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // CDIC read, fixed wait of 2
    cdic_din = 16'h1234;
    q.push_back('{err: 1'b0, data: 16'h1234});
    do_cycle(24'h300010, 1'b0, 1'b1, 1'b1, -1, 6, nm, nc, ns, nn, pa, np);
    check("cdic_cs_cycles", 32'(nc), 32'd2);
    check("cdic_other_cs", 32'(nm + ns + nn), 32'd0);
    check("cdic_ack_cycle", 32'(pa), 32'd3);
    check("cdic_pulses", 32'(np), 32'd1);

    // Slave write, ready on 5th ACCESS cycle, strobe held 20 more cycles
    slave_din = 16'hBEEF;
    q.push_back('{err: 1'b0, data: 16'hBEEF});
    do_cycle(24'h310002, 1'b1, 1'b1, 1'b1, 5, 26, nm, nc, ns, nn, pa, np);
    check("slave_cs_cycles", 32'(ns), 32'd5);
    check("slave_other_cs", 32'(nm + nc + nn), 32'd0);
    check("slave_ack_cycle", 32'(pa), 32'd6);
    check("slave_single_ack", 32'(np), 32'd1);

    // Error region, upper strobe only
    q.push_back('{err: 1'b1, data: 16'h0});
    do_cycle(24'h700000, 1'b0, 1'b1, 1'b0, -1, 4, nm, nc, ns, nn, pa, np);
    check("err_no_cs", 32'(nm + nc + ns + nn), 32'd0);
    check("err_pulse_cycle", 32'(pa), 32'd1);
    check("err_pulses", 32'(np), 32'd1);
    check("data_out_held", 32'(data_out), 32'hBEEF);

    // Unmapped: only a timeout ends it
    q.push_back('{err: 1'b1, data: 16'h0});
    do_cycle(24'h2A0000, 1'b0, 1'b1, 1'b1, -1, 12, nm, nc, ns, nn, pa, np);
    check("none_no_cs", 32'(nm + nc + ns + nn), 32'd0);
    check("none_timeout_cycle", 32'(pa), 32'd9);

    // MCD212 ready on the same cycle as timeout: ready wins
    mcd212_din = 16'hC0DE;
    q.push_back('{err: 1'b0, data: 16'hC0DE});
    do_cycle(24'h000100, 1'b0, 1'b1, 1'b1, 8, 12, nm, nc, ns, nn, pa, np);
    check("mcd_cs_cycles", 32'(nm), 32'd8);
    check("mcd_ack_cycle", 32'(pa), 32'd9);
    check("mcd_pulses", 32'(np), 32'd1);

    // Reset during NVRAM ACCESS: no pulse, everything cleared
    nvram_din = 16'h7777;
    addr = 23'(24'h320000 >> 1); write_strobe = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("nvram_cs_before_reset", 32'(cs_nvram), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_outputs", 32'({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err}), 32'd0);
    check("midreset_data_out", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    as = 1'b0; uds = 1'b0; lds = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Fresh NVRAM read after the reset, wait of 3
    nvram_din = 16'h5A5A;
    q.push_back('{err: 1'b0, data: 16'h5A5A});
    do_cycle(24'h320004, 1'b0, 1'b0, 1'b1, -1, 7, nm, nc, ns, nn, pa, np);
    check("nvram_cs_cycles", 32'(nn), 32'd3);
    check("nvram_ack_cycle", 32'(pa), 32'd4);
    check("nvram_data_out", 32'(data_out), 32'h5A5A);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
